// File: rtl/sample_expander.sv
// Interpolating expander: buffers averaged samples in a small FIFO and emits
// 2**RATIO_LOG2 linearly interpolated outputs per sample over valid/ready.
module sample_expander #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned RATIO_LOG2 = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid_out,
   input  logic              data_ready,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              busy
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned K_W    = RATIO_LOG2 + 1;
   localparam int unsigned PROD_W = DATA_W + RATIO_LOG2 + 2;
   localparam logic [K_W-1:0]   K_LAST    = K_W'(1 << RATIO_LOG2);
   localparam logic [K_W-1:0]   K_FIRST   = K_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic [DATA_W-1:0] prev;
   logic [DATA_W-1:0] cur;
   logic [K_W-1:0]    k;
   logic [DATA_W-1:0] head;
   logic              wr_en;
   logic              pop;
   logic              xfer;
   logic              last;

   // prev + floor((cur - prev) * k / 2**RATIO_LOG2); the sum stays within
   // [prev, cur], so truncating back to DATA_W bits is exact.
   function automatic logic [DATA_W-1:0] interp(input logic [DATA_W-1:0] p,
                                                input logic [DATA_W-1:0] c,
                                                input logic [K_W-1:0]    kk);
      logic signed [DATA_W:0]   diff;
      logic signed [PROD_W-1:0] prod;
      logic signed [PROD_W-1:0] step;
      diff = signed'({1'b0, c}) - signed'({1'b0, p});
      prod = PROD_W'(diff) * signed'(PROD_W'(kk));
      step = prod >>> RATIO_LOG2;
      return DATA_W'($unsigned(step) + PROD_W'(p));
   endfunction

   always_comb begin
      head       = mem[rd_ptr];
      xfer       = data_valid_out && data_ready;
      last       = (k == K_LAST);
      wr_en      = data_valid && !full;
      pop        = !empty && ((state == IDLE) || (state == EMIT && xfer && last));
      count_next = count;
      if (wr_en && !pop) begin
         count_next = count + CNT_ONE;
      end else if (pop && !wr_en) begin
         count_next = count - CNT_ONE;
      end
   end

   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         full           <= 1'b0;
         empty          <= 1'b1;
         overflow       <= 1'b0;
         prev           <= '0;
         cur            <= '0;
         k              <= '0;
         data_out       <= '0;
         data_valid_out <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count <= count_next;
         full  <= (count_next == CNT_FULL);
         empty <= (count_next == '0);
         if (data_valid && full) begin
            overflow <= 1'b1;
         end

         case (state)
            IDLE: begin
               data_valid_out <= 1'b0;
               if (!empty) begin
                  cur            <= head;
                  k              <= K_FIRST;
                  data_out       <= interp(prev, head, K_FIRST);
                  data_valid_out <= 1'b1;
                  state          <= EMIT;
               end
            end
            EMIT: begin
               if (xfer) begin
                  if (!last) begin
                     k        <= k + K_FIRST;
                     data_out <= interp(prev, cur, k + K_FIRST);
                  end else begin
                     prev <= cur;
                     // Next group starts from the sample just finished, with no bubble.
                     if (!empty) begin
                        cur      <= head;
                        k        <= K_FIRST;
                        data_out <= interp(cur, head, K_FIRST);
                     end else begin
                        data_valid_out <= 1'b0;
                        state          <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == EMIT);

endmodule

// File: tb/tb_sample_expander.sv
// Scoreboard bench for sample_expander: stimulus queues hand-computed outputs,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_sample_expander;

   logic       clk_in = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = '0;
   logic       data_valid = 1'b0;
   logic [7:0] data_out;
   logic       data_valid_out;
   logic       data_ready = 1'b1;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int out_count = 0;
   int exp_q[$];

   sample_expander #(.DATA_W(8), .RATIO_LOG2(2), .FIFO_DEPTH(4)) dut (
      .clk_in(clk_in),
      .reset(reset),
      .data_in(data_in),
      .data_valid(data_valid),
      .data_out(data_out),
      .data_valid_out(data_valid_out),
      .data_ready(data_ready),
      .full(full),
      .empty(empty),
      .overflow(overflow),
      .busy(busy)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (data_valid_out && data_ready) begin
         checks++;
         out_count++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %0d, nothing expected", data_out);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(data_out) != e) begin
               errors++;
               $display("FAIL data_out: got %0d expected %0d", data_out, e);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic write(input int v);
      data_in    = 8'(v);
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
   endtask

   task automatic expect4(input int a, input int b, input int c, input int d);
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
      exp_q.push_back(d);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         check({name, "_timeout"}, exp_q.size(), 0);
         exp_q.delete();
      end
      tick();
      check({name, "_valid_after"}, int'(data_valid_out), 0);
      check({name, "_empty_after"}, int'(empty), 1);
      check({name, "_busy_after"}, int'(busy), 0);
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_data_out"}, int'(data_out), 0);
      check({name, "_valid"}, int'(data_valid_out), 0);
      check({name, "_full"}, int'(full), 0);
      check({name, "_empty"}, int'(empty), 1);
      check({name, "_overflow"}, int'(overflow), 0);
      check({name, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int base;
      tick();
      tick();
      reset = 1'b0;
      check_reset_state("rst");

      // First sample after reset: latency and ramp from 0.
      expect4(20, 40, 60, 80);
      write(80);
      check("first_empty", int'(empty), 0);
      check("first_latency_valid", int'(data_valid_out), 0);
      tick();
      check("first_valid", int'(data_valid_out), 1);
      check("first_value", int'(data_out), 20);
      drain("first");

      // Back-to-back groups with no bubble.
      do_reset();
      expect4(20, 40, 60, 80);
      expect4(60, 40, 20, 0);
      write(80);
      write(0);
      for (int i = 0; i < 8; i++) begin
         check("no_bubble", int'(data_valid_out), 1);
         tick();
      end
      check("b2b_end_valid", int'(data_valid_out), 0);
      drain("b2b");

      // Descending floor rounding from prev=10.
      expect4(2, 5, 7, 10);
      expect4(9, 8, 7, 7);
      write(10);
      write(7);
      drain("desc");

      // Backpressure on the second output.
      do_reset();
      expect4(20, 40, 60, 80);
      write(80);
      tick();
      tick();
      data_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("hold_valid", int'(data_valid_out), 1);
         check("hold_value", int'(data_out), 40);
         tick();
      end
      data_ready = 1'b1;
      check("hold_value_last", int'(data_out), 40);
      drain("bp");

      // Overflow: one sample popped, four buffered, sixth dropped.
      do_reset();
      data_ready = 1'b0;
      write(80);
      write(0);
      write(80);
      write(0);
      write(80);
      check("ovf_full", int'(full), 1);
      check("ovf_not_yet", int'(overflow), 0);
      write(0);
      check("ovf_sticky", int'(overflow), 1);
      check("ovf_full_kept", int'(full), 1);
      check("ovf_busy", int'(busy), 1);
      expect4(20, 40, 60, 80);
      expect4(60, 40, 20, 0);
      expect4(20, 40, 60, 80);
      expect4(60, 40, 20, 0);
      expect4(20, 40, 60, 80);
      base = out_count;
      data_ready = 1'b1;
      drain("ovf");
      check("ovf_out_count", out_count - base, 20);
      check("ovf_still_set", int'(overflow), 1);

      // Reset mid-EMIT, prev=80 going to 0.
      exp_q.push_back(60);
      exp_q.push_back(40);
      write(0);
      tick();
      tick();
      check("mid_value", int'(data_out), 40);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_state("midrst");
      check("midrst_q", exp_q.size(), 0);
      expect4(10, 20, 30, 40);
      write(40);
      drain("after_rst");

      check("final_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sample_expander.md
# sample_expander

Single-clock interpolating expander: the inverse of the sample averager that feeds `data_out`/`data_valid_out` downstream. It accepts one averaged 8-bit sample per `data_valid` pulse into a small input FIFO. For each sample it emits `2**RATIO_LOG2` linearly interpolated samples, running from the previous sample to the current one, over a valid/ready output handshake. It sits on the 100 MHz domain after the averager and restores the original sample rate for playback or loop-back checking.

## Interface
- `DATA_W`, 8, sample width (unsigned)
- `RATIO_LOG2`, 2, log2 of outputs per input sample (default 4 outputs)
- `FIFO_DEPTH`, 4, input FIFO entries (power of 2, ≥2)

- `clk_in` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high; clears all state on the next `clk_in` edge
- `data_in` in DATA_W: input sample
- `data_valid` in 1: write strobe, one sample per cycle high
- `data_out` out DATA_W: interpolated output sample
- `data_valid_out` out 1: `data_out` is valid
- `data_ready` in 1: downstream accepts `data_out` this cycle
- `full` out 1: input FIFO holds FIFO_DEPTH entries
- `empty` out 1: input FIFO holds 0 entries
- `overflow` out 1: sticky; a write arrived while `full`
- `busy` out 1: FSM in EMIT

## Operation
- **Reset values:** `data_out`=0, `data_valid_out`=0, `full`=0, `empty`=1, `overflow`=0, `busy`=0. Internal registers: `prev`=0, `cur`=0, `k`=0, FIFO count=0, pointers=0.
- **Input FIFO**
  - A write occurs when `data_valid` is high and `full` is low.
  - A write while `full` is dropped, with the FIFO unchanged and `overflow` set to 1 until `reset`.
  - A simultaneous write and pop leaves the count unchanged.
  - `full` and `empty` are registered and reflect the count after the current edge.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM IDLE**
  - `data_valid_out`=0.
  - If `empty`=0: pop the head into `cur`, set `k`=1, go to EMIT.
- **FSM EMIT**
  - `data_valid_out`=1.
  - `data_out` = `prev` + floor(((`cur`−`prev`)·`k`) / 2**RATIO_LOG2).
  - Compute the difference as a signed DATA_W+1-bit value and the product at DATA_W+RATIO_LOG2+2 bits, then arithmetic-shift right by RATIO_LOG2 (floor toward −∞).
  - The result always lies between `prev` and `cur` inclusive, so it cannot overflow.
- **Handshake in EMIT**
  - A transfer occurs when `data_valid_out` && `data_ready`.
  - With no transfer, `data_out` and `data_valid_out` hold stable.
  - On transfer with `k` < 2**RATIO_LOG2: `k`←`k`+1.
  - On transfer with `k` = 2**RATIO_LOG2: `prev`←`cur`.
    - If the FIFO is non-empty, pop the next head into `cur`, set `k`=1, stay in EMIT (back-to-back, no bubble).
    - Otherwise go to IDLE.
- **Last sample of each group:** the final output equals `cur` exactly.
- **Reset mid-EMIT:** the in-flight group and FIFO contents are discarded. `prev` returns to 0, so the first sample after reset interpolates from 0.
- **`data_out` registering:** `data_out` is driven from registers, with no combinational path from `data_ready` or `data_in` to any output.

## Timing
- A write at edge t makes `empty`=0 after edge t.
- The IDLE pop happens at edge t+1; `data_valid_out`=1 with the first output from t+1 until the first transfer.
- Latency from write to first output valid is 1 cycle after the write edge, for an idle block with an empty FIFO.
- Throughput is one output per cycle while `data_ready`=1. Sustained input rate is 1 sample per 2**RATIO_LOG2 cycles without overflow.
- The FIFO pop and the last-output transfer occur on the same edge. The FIFO count reflects it on the next cycle.

## Test plan
- **First sample after reset:** reset, then write 80, `data_ready`=1 → outputs 20, 40, 60, 80 on consecutive cycles. Then `data_valid_out`=0, `empty`=1.
- **Back-to-back samples:** write 80 and then 0, queued → 20, 40, 60, 80, 60, 40, 20, 0 with no bubble between groups.
- **Descending floor rounding:** `prev`=10, write 7 → 9, 8, 7, 7.
- **Backpressure:** during a group, drive `data_ready` low for 3 cycles on the second output → `data_out`=40 held for 4 cycles with `data_valid_out`=1. The sequence then resumes at 60.
- **Overflow:** with `data_ready`=0, write 6 samples on consecutive cycles → 1 popped into `cur`, 4 in the FIFO. `full`=1 after the 5th write; the 6th write is dropped and `overflow`=1. Raising `data_ready` then yields exactly 5 groups (20 outputs).
- **Reset mid-EMIT:** assert `reset` for 1 cycle during the 2nd output → next cycle all outputs are at reset values and `overflow`=0. A new write of 40 then yields 10, 20, 30, 40.
